map_select_ctrl: RTL
====================

Name: map_select_ctrl

Overview:
Parametrised map/screen selection controller for the game top level. It generalises the two-button map select to NUM_MAPS maps chosen with next/prev/confirm buttons. Raw buttons are synchronised and edge-detected internally. Screen sequencing (start, select, play, game-over) is tracked in a registered FSM that feeds the animation and draw datapath.

Parameters:
NUM_MAPS, 4, number of selectable maps (2..16)
MAP_W, $clog2(NUM_MAPS) (min 1), width of map index
STATE_W, 6, width of the main control FSM state bus
SELECT_STATE, 6'd11, main-FSM state code in which map selection is armed

Ports:
clk  input  1  system clock, all logic rising-edge
resetn  input  1  asynchronous active-low reset
current_state  input  STATE_W  main control FSM state
btn_next  input  1  raw button, advance cursor (asynchronous, active-high)
btn_prev  input  1  raw button, retreat cursor (asynchronous, active-high)
btn_confirm  input  1  raw button, commit / acknowledge (asynchronous, active-high)
game_over  input  1  level from game logic, end of round
cursor  output  MAP_W  map currently highlighted on the select screen
map_sel  output  MAP_W  committed map index
map_valid  output  1  one-cycle pulse on commit
screen  output  2  2'b10 START, 2'b00 MAP, 2'b11 GG (2'b01 never driven)

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM = S_START; cursor = 0; map_sel = 0; map_valid = 0; screen = 2'b10.
  - Synchroniser and edge registers cleared.
  - Reset mid-selection or mid-play discards all progress.
- Button path, per button: 2-flop synchroniser then previous-value register; rise = sync2 & ~prev.
  - A button high before edge k produces rise during the cycle after edge k+1, so the action takes effect at edge k+2.
  - A held button gives exactly one rise; it must go low for at least 1 sampled cycle to re-arm.
- FSM states and transitions:
  - S_START (screen 10): enter S_SELECT when current_state == SELECT_STATE. cursor is held, not reset, so the last choice is remembered.
  - S_SELECT (screen 10):
    - rise_next alone: cursor = cursor+1, wrapping NUM_MAPS-1 -> 0.
    - rise_prev alone: cursor = cursor-1, wrapping 0 -> NUM_MAPS-1.
    - rise_next and rise_prev in the same cycle: no move.
    - rise_confirm: map_sel <= cursor (pre-move value, confirm takes priority over any same-cycle next/prev), map_valid = 1 for exactly that following cycle, go to S_PLAY.
    - current_state != SELECT_STATE without confirm: return to S_START; map_sel unchanged, no pulse.
  - S_PLAY (screen 00): buttons ignored; game_over == 1 -> S_GG.
  - S_GG (screen 11): rise_confirm -> S_START; game_over level ignored.
- Arithmetic:
  - Wrap is explicit compare, not modulo-2^MAP_W, so non-power-of-2 NUM_MAPS never yields an index >= NUM_MAPS.
  - map_sel and cursor are always < NUM_MAPS.
- All outputs are registered; screen is decoded from the state register with no combinational path from inputs.
- map_valid is never high for 2 consecutive cycles.

Test Plan:
- Reset then current_state=11, NUM_MAPS=4, pulse btn_next 5 times (each 3 cycles high, 3 low) -> cursor 1,2,3,0,1; screen stays 2'b10.
- NUM_MAPS=3, cursor=0, one btn_prev pulse -> cursor=2 (not 3); a further btn_next -> cursor=0.
- Cursor=2, btn_confirm and btn_next rise in the same cycle -> map_sel=2, map_valid high exactly 1 cycle, screen=2'b00, cursor not advanced.
- Hold btn_next high for 20 cycles in S_SELECT -> cursor advances by exactly 1; rise reaches cursor 2 edges after first sample.
- In S_PLAY assert game_over -> screen=2'b11 next cycle; btn_next ignored; btn_confirm -> screen=2'b10 with map_sel retained.
- In S_SELECT with cursor=3, drive resetn=0 between clock edges -> cursor, map_sel, map_valid go to 0 and screen to 2'b10 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/map_select_ctrl.sv
// Map/screen selection controller: synchronised, edge-detected next/prev/confirm buttons drive a cursor over NUM_MAPS maps.
// Button actions land two edges after the first sample; there is no backpressure, and map_valid is a single-cycle pulse.
module map_select_ctrl #(
  parameter int                 NUM_MAPS     = 4,
  parameter int                 MAP_W        = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  parameter int                 STATE_W      = 6,
  parameter logic [STATE_W-1:0] SELECT_STATE = 6'd11
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [STATE_W-1:0] current_state,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               btn_confirm,
  input  logic               game_over,
  output logic [MAP_W-1:0]   cursor,
  output logic [MAP_W-1:0]   map_sel,
  output logic               map_valid,
  output logic [1:0]         screen
);

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_SELECT = 2'd1,
    S_PLAY   = 2'd2,
    S_GG     = 2'd3
  } state_t;

  localparam logic [MAP_W-1:0] LAST_MAP = MAP_W'(NUM_MAPS - 1);

  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] rise;
  logic       rise_next, rise_prev, rise_confirm;

  state_t           state_q, state_d;
  logic [MAP_W-1:0] cursor_q, cursor_d;
  logic [MAP_W-1:0] map_sel_q, map_sel_d;
  logic             map_valid_q, map_valid_d;

  // Bit order: [0] next, [1] prev, [2] confirm.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {btn_confirm, btn_prev, btn_next};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise         = sync2_q & ~prev_q;
  assign rise_next    = rise[0];
  assign rise_prev    = rise[1];
  assign rise_confirm = rise[2];

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    map_sel_d   = map_sel_q;
    map_valid_d = 1'b0;
    case (state_q)
      S_START: begin
        if (current_state == SELECT_STATE) state_d = S_SELECT;
      end
      S_SELECT: begin
        // Confirm commits the pre-move cursor, so it outranks next/prev and leaving.
        if (rise_confirm) begin
          map_sel_d   = cursor_q;
          map_valid_d = 1'b1;
          state_d     = S_PLAY;
        end else if (current_state != SELECT_STATE) begin
          state_d = S_START;
        end else if (rise_next && !rise_prev) begin
          cursor_d = (cursor_q == LAST_MAP) ? '0 : cursor_q + MAP_W'(1);
        end else if (rise_prev && !rise_next) begin
          cursor_d = (cursor_q == '0) ? LAST_MAP : cursor_q - MAP_W'(1);
        end
      end
      S_PLAY: begin
        if (game_over) state_d = S_GG;
      end
      S_GG: begin
        if (rise_confirm) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_START;
      cursor_q    <= '0;
      map_sel_q   <= '0;
      map_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      map_sel_q   <= map_sel_d;
      map_valid_q <= map_valid_d;
    end
  end

  always_comb begin
    screen = 2'b10;
    case (state_q)
      S_PLAY:  screen = 2'b00;
      S_GG:    screen = 2'b11;
      default: screen = 2'b10;
    endcase
  end

  assign cursor    = cursor_q;
  assign map_sel   = map_sel_q;
  assign map_valid = map_valid_q;

endmodule
